// File: rtl/gpu_pkg.sv
// Shared GPU framebuffer constants, the fb_mem state type and the pixel-to-byte address helper.
package gpu_pkg;

  localparam int unsigned FB_W      = 320;
  localparam int unsigned FB_H      = 200;
  localparam int unsigned FB_STRIDE = FB_W / 8;
  localparam int unsigned FB_BYTES  = FB_STRIDE * FB_H;
  localparam int unsigned FB_AW     = 13;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StFetch,
    StMerge,
    StWrite
  } fb_state_e;

  // y*40 + x/8 using shifts, so no multiplier is inferred
  function automatic logic [FB_AW-1:0] fb_byte_addr(input logic [8:0] x, input logic [7:0] y);
    logic [FB_AW-1:0] yw;
    yw = FB_AW'(y);
    return (yw << 5) + (yw << 3) + FB_AW'(x[8:3]);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous RAM with registered read; a write cycle leaves the read register alone.
module fb_ram #(
  parameter int unsigned Depth = 8000,
  parameter int unsigned AddrW = 13
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AddrW-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/fb_mem.sv
// 1bpp pixel-addressed framebuffer: pixel read / read-modify-write FSM sharing one RAM port
// with a byte-wide scanout reader that always wins arbitration.
module fb_mem #(
  parameter int unsigned FB_W      = 320,
  parameter int unsigned FB_H      = 200,
  parameter int unsigned FB_STRIDE = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  x_b,
  input  logic [7:0]  y_b,
  input  logic        read_b,
  input  logic        write_b,
  input  logic        in_b,
  output logic        out_b,
  output logic        rdy_b,
  input  logic        scan_en,
  input  logic [12:0] scan_addr,
  output logic [7:0]  scan_data,
  output logic        scan_valid
);
  import gpu_pkg::*;

  fb_state_e        state_q, state_d;
  logic             rdy_q, rdy_d;
  logic             out_q, out_d;
  logic             scan_valid_q;
  logic             op_write_q, op_write_d;
  logic             din_q, din_d;
  logic [2:0]       bit_q, bit_d;
  logic [FB_AW-1:0] addr_q, addr_d;
  logic [7:0]       wr_byte_q, wr_byte_d;

  logic             ram_en, ram_we;
  logic [FB_AW-1:0] ram_addr;
  logic [7:0]       ram_wdata, ram_rdata, merged;
  logic             out_of_range;

  assign out_of_range = (32'(x_b) >= FB_W) || (32'(y_b) >= FB_H);

  always_comb begin
    merged         = ram_rdata;
    merged[bit_q]  = din_q;
  end

  always_comb begin
    state_d    = state_q;
    rdy_d      = rdy_q;
    out_d      = out_q;
    op_write_d = op_write_q;
    din_d      = din_q;
    bit_d      = bit_q;
    addr_d     = addr_q;
    wr_byte_d  = wr_byte_q;
    // scanout owns the port whenever it asks; pixel traffic only overrides when it is idle
    ram_en     = scan_en;
    ram_we     = 1'b0;
    ram_addr   = scan_addr;
    ram_wdata  = merged;

    unique case (state_q)
      StIdle: begin
        if (read_b || write_b) begin
          op_write_d = ~read_b;
          din_d      = in_b;
          bit_d      = x_b[2:0];
          addr_d     = fb_byte_addr(x_b, y_b);
          rdy_d      = 1'b0;
          state_d    = out_of_range ? StAck : StFetch;
        end
      end
      StAck: begin
        if (!op_write_q) out_d = 1'b0;
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
      StFetch: begin
        if (!scan_en) begin
          ram_en   = 1'b1;
          ram_addr = addr_q;
          state_d  = StMerge;
        end
      end
      StMerge: begin
        if (!op_write_q) begin
          out_d   = ram_rdata[bit_q];
          rdy_d   = 1'b1;
          state_d = StIdle;
        end else if (!scan_en) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = addr_q;
          rdy_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          // RAM output is about to be overwritten by the scan read, so park the merged byte
          wr_byte_d = merged;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        if (!scan_en) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = addr_q;
          ram_wdata = wr_byte_q;
          rdy_d     = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rdy_q        <= 1'b1;
      out_q        <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      out_q        <= out_d;
      scan_valid_q <= scan_en;
    end
  end

  always_ff @(posedge clk) begin
    op_write_q <= op_write_d;
    din_q      <= din_d;
    bit_q      <= bit_d;
    addr_q     <= addr_d;
    wr_byte_q  <= wr_byte_d;
  end

  // a reset edge must never commit an in-flight write
  fb_ram #(
    .Depth(FB_STRIDE * FB_H),
    .AddrW(FB_AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we & rst_n),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign out_b      = out_q;
  assign rdy_b      = rdy_q;
  assign scan_valid = scan_valid_q;
  assign scan_data  = ram_rdata;

endmodule
